// File: rtl/led_strip_pkg.sv
// led_strip_pkg: shared state encoding and default WS2812 timing for the LED strip refresh path.
package led_strip_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, SEND, GAP} state_t;
  localparam int DEF_NUM_LEDS = 50;
  localparam int DEF_T0H = 20;
  localparam int DEF_T1H = 40;
  localparam int DEF_TBIT = 62;
  localparam int DEF_TRESET = 3000;
endpackage

// File: rtl/ws2812_bit_encoder.sv
// ws2812_bit_encoder: one WS2812 bit per start pulse, high T0H/T1H cycles then low to TBIT total.
module ws2812_bit_encoder
  import led_strip_pkg::*;
#(
  parameter int T0H = DEF_T0H,
  parameter int T1H = DEF_T1H,
  parameter int TBIT = DEF_TBIT
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic bit_val,
  output logic data_out,
  output logic done
);
  localparam int CW = TBIT > 1 ? $clog2(TBIT) : 1;
  logic [CW-1:0] cnt, hi;
  logic active;
  // done marks the final low cycle, so a start on that edge keeps bits gap-free
  assign done = active && cnt == CW'(TBIT - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      hi <= '0;
      active <= 1'b0;
      data_out <= 1'b0;
    end else if (start) begin
      cnt <= '0;
      hi <= bit_val ? CW'(T1H) : CW'(T0H);
      active <= 1'b1;
      data_out <= 1'b1;
    end else if (active) begin
      if (done) begin
        active <= 1'b0;
        data_out <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
        data_out <= cnt + 1'b1 < hi;
      end
    end
endmodule

// File: rtl/led_strip_refresh_controller.sv
// led_strip_refresh_controller: on activity, streams NUM_LEDS GRB colours to a WS2812 strip then holds the latch gap.
module led_strip_refresh_controller
  import led_strip_pkg::*;
#(
  parameter int NUM_LEDS = DEF_NUM_LEDS,
  parameter int T0H = DEF_T0H,
  parameter int T1H = DEF_T1H,
  parameter int TBIT = DEF_TBIT,
  parameter int TRESET = DEF_TRESET
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        activity,
  input  logic [23:0] color,
  output logic [7:0]  led_index,
  output logic        data_out,
  output logic        busy
);
  localparam int GW = TRESET > 1 ? $clog2(TRESET) : 1;
  localparam logic [7:0] LAST = 8'(NUM_LEDS - 1);
  state_t state;
  logic pending, bit_start, bit_val, bit_done;
  logic [4:0] bit_cnt;
  logic [23:0] shreg;
  logic [GW-1:0] gap_cnt;
  always_comb begin
    bit_start = state == FETCH || (state == SEND && bit_done && bit_cnt != 5'd0);
    bit_val = state == FETCH ? color[23] : shreg[22];
  end
  ws2812_bit_encoder #(.T0H(T0H), .T1H(T1H), .TBIT(TBIT)) u_enc (
    .clk(clk),
    .reset(reset),
    .start(bit_start),
    .bit_val(bit_val),
    .data_out(data_out),
    .done(bit_done)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      led_index <= '0;
      pending <= 1'b0;
      bit_cnt <= '0;
      shreg <= '0;
      gap_cnt <= '0;
    end else begin
      if (activity && state != IDLE) pending <= 1'b1;
      case (state)
        IDLE:
          if (activity) begin
            state <= FETCH;
            busy <= 1'b1;
            led_index <= '0;
          end
        FETCH: begin
          shreg <= color;
          bit_cnt <= 5'd23;
          state <= SEND;
        end
        SEND:
          if (bit_done) begin
            if (bit_cnt != 5'd0) begin
              bit_cnt <= bit_cnt - 5'd1;
              shreg <= {shreg[22:0], 1'b0};
            end else if (led_index == LAST) begin
              state <= GAP;
              gap_cnt <= '0;
            end else begin
              led_index <= led_index + 8'd1;
              state <= FETCH;
            end
          end
        GAP:
          if (gap_cnt == GW'(TRESET - 1)) begin
            // a request landing on this very edge counts as pending
            led_index <= '0;
            pending <= 1'b0;
            state <= pending || activity ? FETCH : IDLE;
            busy <= pending || activity;
          end else gap_cnt <= gap_cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule
